seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 152 +++++++++++++++
 tb/tb_seq_divider.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Multi-cycle unsigned restoring divider. Computes the quotient
//             and remainder of two DATA_WIDTH-bit operands, one
//             subtract-and-shift step per clock, behind a START/BUSY/DONE
//             handshake so that several controllers can share one
//             subtract chain.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1           clock, all state changes on the rising edge
//    rst    in   1           asynchronous, active-high reset
//    start  in   1           request; sampled only while busy is low
//    a      in   DATA_WIDTH  dividend, latched when start is accepted
//    b      in   DATA_WIDTH  divisor, latched when start is accepted
//    busy   out  1           division in progress; start is ignored
//    done   out  1           one-cycle pulse, q/r/dz valid
//    q      out  DATA_WIDTH  quotient, held until the next result
//    r      out  DATA_WIDTH  remainder, held until the next result
//    dz     out  1           divide-by-zero flag for the last result
// ============================================================================
module seq_divider #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] r,
  output logic                  dz
);

  localparam int             STEP_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DATA_WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]            state;
  logic [STEP_W-1:0]     step;
  // Dividend shift register. Dividend bits leave at the top while quotient
  // bits enter at the bottom, so after DATA_WIDTH steps it holds the quotient.
  logic [DATA_WIDTH-1:0] dvd;
  logic [DATA_WIDTH-1:0] dsr;
  // Partial remainder between steps. It is always below the divisor, so
  // DATA_WIDTH bits suffice; the extra bit only exists after the shift.
  logic [DATA_WIDTH-1:0] rem;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;
  logic [DATA_WIDTH:0]   borrow;
  logic                  no_borrow;
  logic [DATA_WIDTH-1:0] rem_next;
  logic                  dsr_zero;
  logic                  accept;

  // {P, next dividend bit}
  assign shifted = {rem, dvd[DATA_WIDTH-1]};

  // Ripple borrow chain for shifted - {0, dsr}. Only the low DATA_WIDTH
  // difference bits are kept; the top position just resolves the final
  // borrow against the zero-extended divisor.
  assign borrow[0] = 1'b0;
  generate
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_borrow
      assign diff[i]       = shifted[i] ^ dsr[i] ^ borrow[i];
      assign borrow[i + 1] = (~shifted[i] & dsr[i]) |
                             (~(shifted[i] ^ dsr[i]) & borrow[i]);
    end
  endgenerate

  // Top bit of the divisor operand is 0: the subtraction borrows out only
  // when shifted[DATA_WIDTH] is 0 and a borrow arrives from below.
  assign no_borrow = shifted[DATA_WIDTH] | ~borrow[DATA_WIDTH];

  // Restoring step: keep the difference when it fits, else keep P. When the
  // difference is kept it is below the divisor, so its top bit is zero.
  assign rem_next = no_borrow ? diff : shifted[DATA_WIDTH-1:0];

  assign dsr_zero = (dsr == '0);

  // New work is accepted both in IDLE and in FIN, giving back-to-back issue.
  assign accept = start & ((state == IDLE) | (state == FIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      dvd   <= '0;
      dsr   <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dvd   <= a;
        dsr   <= b;
        rem   <= '0;
        step  <= '0;
        busy  <= 1'b1;
        state <= CALC;
      end else begin
        case (state)
          CALC: begin
            if (dsr_zero) begin
              // One busy cycle, then report the divide-by-zero result.
              // dvd has not been shifted, so it still holds the dividend.
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
              q     <= '1;
              r     <= dvd;
              dz    <= 1'b1;
            end else begin
              rem  <= rem_next;
              dvd  <= {dvd[DATA_WIDTH-2:0], no_borrow};
              step <= step + STEP_W'(1);
              if (step == LAST_STEP) begin
                // Results are captured from the final step's combinational
                // values so they appear together with done.
                state <= FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
                q     <= {dvd[DATA_WIDTH-2:0], no_borrow};
                r     <= rem_next;
                dz    <= 1'b0;
              end
            end
          end
          FIN: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider at DATA_WIDTH 8 and 16.
//             Directed cases plus randomized operands compared with plain
//             integer division and modulo.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8;
  logic [7:0]  a8, b8, q8, r8;
  logic        busy8, done8, dz8;

  logic        start16;
  logic [15:0] a16, b16, q16, r16;
  logic        busy16, done16, dz16;

  seq_divider #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .q(q8), .r(r8), .dz(dz8)
  );

  seq_divider #(.DATA_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .q(q16), .r(r16), .dz(dz16)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        dz;
    logic [15:0] q;
    logic [15:0] r;
  } obs_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit wide, input logic st, input logic [15:0] a, input logic [15:0] b);
    if (wide) begin
      start16 = st; a16 = a; b16 = b;
    end else begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  function automatic obs_t observe(input bit wide);
    obs_t o;
    if (wide) begin
      o.busy = busy16; o.done = done16; o.dz = dz16; o.q = q16; o.r = r16;
    end else begin
      o.busy = busy8; o.done = done8; o.dz = dz8; o.q = {8'd0, q8}; o.r = {8'd0, r8};
    end
    return o;
  endfunction

  // Reference: unsigned division from the arithmetic definition.
  task automatic model(input bit wide, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] eq, output logic [15:0] er, output logic edz);
    logic [15:0] ones;
    ones = wide ? 16'hFFFF : 16'h00FF;
    if (b == 16'd0) begin
      eq = ones; er = a; edz = 1'b1;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0;
    end
  endtask

  // Issue one division, scramble the operand inputs after acceptance, and
  // check latency, busy length, result and the hold after done.
  task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] b, input string tag);
    obs_t        o;
    int          w;
    int          idx;
    int          busy_n;
    logic [15:0] eq, er;
    logic        edz;
    w = wide ? 16 : 8;
    model(wide, a, b, eq, er, edz);
    @(negedge clk);
    drive(wide, 1'b1, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(wide, 1'b0, 16'($urandom), 16'($urandom));
    idx    = 1;
    busy_n = 0;
    o      = observe(wide);
    while (idx <= 40) begin
      o = observe(wide);
      check({tag, " busy&done"}, {31'd0, o.busy & o.done}, 32'd0);
      if (o.busy) busy_n++;
      if (o.done) break;
      idx++;
      @(negedge clk);
    end
    check({tag, " latency"}, idx, (b == 16'd0) ? 2 : w + 1);
    check({tag, " busy cycles"}, busy_n, (b == 16'd0) ? 1 : w);
    check({tag, " q"}, {16'd0, o.q}, {16'd0, eq});
    check({tag, " r"}, {16'd0, o.r}, {16'd0, er});
    check({tag, " dz"}, {31'd0, o.dz}, {31'd0, edz});
    @(negedge clk);
    o = observe(wide);
    check({tag, " done pulse"}, {31'd0, o.done}, 32'd0);
    check({tag, " q hold"}, {16'd0, o.q}, {16'd0, eq});
  endtask

  initial begin
    int          idx;
    int          extra;
    logic [15:0] ra, rb;
    obs_t        o;

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'd0, 16'd0);
    drive(1'b1, 1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    for (int wd = 0; wd < 2; wd++) begin
      o = observe(wd[0]);
      check("reset busy", {31'd0, o.busy}, 32'd0);
      check("reset done", {31'd0, o.done}, 32'd0);
      check("reset q",    {16'd0, o.q}, 32'd0);
      check("reset r",    {16'd0, o.r}, 32'd0);
      check("reset dz",   {31'd0, o.dz}, 32'd0);
    end
    rst = 1'b0;

    // Directed results at width 8.
    run_op(1'b0, 16'd100, 16'd7,  "100/7");
    run_op(1'b0, 16'd255, 16'd1,  "255/1");
    run_op(1'b0, 16'd5,   16'd9,  "5/9");
    run_op(1'b0, 16'd0,   16'd3,  "0/3");
    run_op(1'b0, 16'd42,  16'd0,  "42/0");
    run_op(1'b0, 16'd200, 16'd10, "200/10");
    run_op(1'b0, 16'd255, 16'd255, "255/255");

    // START pulsed mid-operation with different operands is ignored.
    @(negedge clk);
    drive(1'b0, 1'b1, 16'd100, 16'd7);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'd9, 16'd3);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'd200, 16'd50);
    idx = 4;
    while (!done8 && idx < 40) begin
      @(negedge clk);
      idx++;
    end
    check("inflight latency", idx, 9);
    check("inflight q", {24'd0, q8}, 32'd14);
    check("inflight r", {24'd0, r8}, 32'd2);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("inflight extra done", extra, 0);

    // Back-to-back: START held through FIN with 77/8.
    @(negedge clk);
    drive(1'b0, 1'b1, 16'd100, 16'd7);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'd77, 16'd8);
    idx = 1;
    while (!done8 && idx < 40) begin
      @(negedge clk);
      idx++;
    end
    check("b2b first latency", idx, 9);
    check("b2b first q", {24'd0, q8}, 32'd14);
    check("b2b first r", {24'd0, r8}, 32'd2);
    @(negedge clk);
    check("b2b busy restart", {31'd0, busy8}, 32'd1);
    check("b2b done low", {31'd0, done8}, 32'd0);
    check("b2b old q held", {24'd0, q8}, 32'd14);
    drive(1'b0, 1'b0, 16'd0, 16'd0);
    idx = 1;
    while (!done8 && idx < 40) begin
      if (idx == 4) check("b2b mid r held", {24'd0, r8}, 32'd2);
      @(negedge clk);
      idx++;
    end
    check("b2b second latency", idx, 9);
    check("b2b second q", {24'd0, q8}, 32'd9);
    check("b2b second r", {24'd0, r8}, 32'd5);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    drive(1'b0, 1'b1, 16'd100, 16'd7);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", {31'd0, busy8}, 32'd0);
    check("async rst done", {31'd0, done8}, 32'd0);
    check("async rst q",    {24'd0, q8}, 32'd0);
    check("async rst r",    {24'd0, r8}, 32'd0);
    check("async rst dz",   {31'd0, dz8}, 32'd0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done8) extra++;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("aborted op done", extra, 0);
    run_op(1'b0, 16'd100, 16'd7, "post-rst 100/7");

    // Randomized operands at both widths, with zero and small divisors mixed in.
    for (int wd = 0; wd < 2; wd++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = 16'($urandom);
        case ($urandom_range(0, 9))
          0:       rb = 16'd0;
          1, 2, 3: rb = 16'($urandom_range(1, 15));
          default: rb = 16'($urandom);
        endcase
        if (wd == 0) begin
          ra = ra & 16'h00FF;
          rb = rb & 16'h00FF;
        end
        run_op(wd[0], ra, rb, (wd == 0) ? "rnd8" : "rnd16");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
